dfr_reservoir_core: RTL and testbench
=====================================

# dfr_reservoir_core

Parametrised delayed-feedback reservoir core: one input sample is expanded by a binary ±1 mask into VIRTUAL_NODES node updates, each combining the scaled masked input with that node's value from the previous sample. The core sits between the input sample stream and the readout layer. It supersedes the fixed-configuration reservoir with:

- a ready/valid handshake on both sides;
- runtime input and feedback gains;
- a runtime mask;
- node-indexed output with a frame-last flag.

## Interface
- VIRTUAL_NODES, 10: nodes per sample; delay-line depth; ≥2.
- DATA_WIDTH, 32: signed fixed-point word width.
- FRAC_BITS, 16: fractional bits; 1.0 = 2^FRAC_BITS.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the next rising edge).
- s_valid  input  1  input sample valid.
- s_ready  output  1  core can accept a sample.
- din  input  DATA_WIDTH  input sample u, signed fixed point.
- alpha  input  DATA_WIDTH  input gain, signed fixed point.
- beta  input  DATA_WIDTH  feedback gain, signed fixed point.
- mask  input  VIRTUAL_NODES  bit i=1 → +u for node i; bit i=0 → −u.
- m_valid  output  1  dout holds a node value.
- m_ready  input  1  downstream accepts dout.
- dout  output  DATA_WIDTH  node value.
- m_idx  output  $clog2(VIRTUAL_NODES)  node index of dout.
- m_last  output  1  dout is node VIRTUAL_NODES−1.

## Operation
- **States:**
  - IDLE: s_ready=1.
  - RUN: s_ready=0.
- **IDLE→RUN:** on s_valid&&s_ready.
  - din, alpha, beta and mask are captured into frame registers.
  - Node counter is set to 0.
  - Input changes during RUN have no effect.
- **Node step in RUN:** fires when the output register is free (!m_valid || m_ready).
  - Compute x_i = sat(fixmul(alpha, m_i·u) + fixmul(beta, d[i])).
    - d[i] is the delay-line entry i.
    - m_i·u is u or −u; two's-complement negation, and −min saturates to max.
  - fixmul: full 2·DATA_WIDTH signed product, arithmetic shift right by FRAC_BITS, saturate to DATA_WIDTH.
  - Sum: computed at DATA_WIDTH+1 bits, saturated to DATA_WIDTH.
  - Write x_i into d[i] and into dout. Set m_valid=1, m_idx=i, m_last=(i==VIRTUAL_NODES−1).
  - Increment the counter.
  - On the step for i=VIRTUAL_NODES−1, go to IDLE in the same edge.
- **Output handshake:**
  - dout, m_idx and m_last are stable while m_valid && !m_ready.
  - m_valid clears on m_ready when no new step fires.
  - Nodes are never skipped or duplicated.
- **Delay line:** holds the previous frame's node values. All zero after reset.

## Timing
- **Reset values:** s_ready=0 while rst=0 and 1 after the first edge with rst=1; m_valid=0; dout=0; m_idx=0; m_last=0; state IDLE; delay line zero; frame registers zero.
- **Latency:** sample accepted at edge k → node i at edge k+1+i, with no backpressure.
- **Throughput:** state is IDLE after edge k+VIRTUAL_NODES, so the next accept is at edge k+VIRTUAL_NODES+1 at the earliest. One sample per VIRTUAL_NODES+1 cycles.
- **Backpressure:** any m_ready=0 cycle with m_valid=1 stalls the counter by one cycle.
- **Simultaneous events:**
  - In IDLE, m_ready consumption of the last node and a new accept in the same cycle are both honoured.
  - In RUN, m_ready and a node step in the same cycle replace dout.
- **Reset mid-frame:** the frame is abandoned, the delay line is zeroed and all outputs return to reset values. The next frame sees zero feedback.
- **Counter:** wraps to 0 only via the →IDLE transition. No state beyond VIRTUAL_NODES−1 is reachable.

## Configuration
- RESERVOIR_NL_EN:
  - **Defined:** x_i is additionally clamped to [−2^FRAC_BITS, +2^FRAC_BITS] (hard-tanh nonlinearity) before writing to dout and d[i].
  - **Undefined:** identity nonlinearity; only DATA_WIDTH saturation applies.

## Structure
- **Package reservoir_pkg:**
  - state enum (IDLE, RUN);
  - sat and fixmul functions, parametrised via function arguments or localparams derived from DATA_WIDTH/FRAC_BITS;
  - ONE constant helper.
- **Sub-module reservoir_node_mac:** combinational node update, taking u, mask bit, alpha, beta and d[i] and producing x_i, including the RESERVOIR_NL_EN clamp.
- **Top:** owns the FSM, counter, frame registers, delay line and output register.

## Test plan
Common configuration: VIRTUAL_NODES=4, DATA_WIDTH=32, FRAC_BITS=16.
- **Reset:** hold rst=0 for 3 edges → m_valid=0, dout=0, s_ready=0. After release, s_ready=1 on the next edge.
- **Mask:** alpha=0x10000, beta=0, mask=4'b0101, din=0x8000 → dout 0x00008000, 0xFFFF8000, 0x00008000, 0xFFFF8000; m_idx 0..3; m_last only on idx 3; s_ready reasserts one cycle later.
- **Feedback:** alpha=beta=0x8000, mask=4'b1111, din=0x10000 for two frames → frame 1 all 0x8000; frame 2 all 0xC000.
- **Clamp:** alpha=beta=0x10000, din=0x10000 for three frames:
  - with RESERVOIR_NL_EN → 0x10000 in every frame;
  - without → 0x10000, 0x20000, 0x30000.
- **Backpressure:** m_ready=0 for 3 cycles while idx 1 is valid → dout/m_idx hold at idx 1, s_ready stays 0, and idx 2 follows the first m_ready=1.
- **Mid-frame reset:** rst=0 after idx 1 → outputs return to reset values. A repeat of the feedback frame then yields 0x8000, proving the delay line was cleared.

Source files
------------

// File: rtl/reservoir_pkg.sv
// Shared types and fixed-point arithmetic for the delayed-feedback reservoir.
// Arithmetic is done in a wide signed container (CALC_W bits) so that one set
// of functions serves every DATA_WIDTH up to MAX_DATA_W. Callers pass the
// target word width and fractional bits as arguments.
package reservoir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned CALC_W     = 2 * MAX_DATA_W;

  typedef logic signed [CALC_W-1:0] calc_t;

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic calc_t sat(input calc_t v, input int unsigned w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // Fixed-point multiply: full product, arithmetic shift by f, saturate to w bits.
  function automatic calc_t fixmul(input calc_t a, input calc_t b,
                                   input int unsigned w, input int unsigned f);
    calc_t p;
    p = a * b;
    p = p >>> f;
    return sat(p, w);
  endfunction

  // The value 1.0 in a format with f fractional bits.
  function automatic calc_t fx_one(input int unsigned f);
    return calc_t'(1) <<< f;
  endfunction

endpackage

// File: rtl/reservoir_node_mac.sv
// Combinational node update for one virtual node:
//   x = sat(fixmul(alpha, +/-u) + fixmul(beta, d))
// Build option RESERVOIR_NL_EN adds a hard-tanh clamp to [-1.0, +1.0].
// DATA_WIDTH must not exceed reservoir_pkg::MAX_DATA_W.
module reservoir_node_mac
  import reservoir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic [DATA_WIDTH-1:0] u_i,
  input  logic                  mask_bit_i,
  input  logic [DATA_WIDTH-1:0] alpha_i,
  input  logic [DATA_WIDTH-1:0] beta_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] x_o
);

  function automatic logic [DATA_WIDTH-1:0] node_update(
    input logic [DATA_WIDTH-1:0] u, input logic mbit,
    input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] d);
    calc_t u_w, a_w, b_w, d_w, mu, sum;
    u_w = calc_t'($signed(u));
    a_w = calc_t'($signed(a));
    b_w = calc_t'($signed(b));
    d_w = calc_t'($signed(d));
    // Negating the most negative word saturates to the most positive one.
    mu  = mbit ? u_w : sat(-u_w, DATA_WIDTH);
    sum = sat(fixmul(a_w, mu, DATA_WIDTH, FRAC_BITS) +
              fixmul(b_w, d_w, DATA_WIDTH, FRAC_BITS), DATA_WIDTH);
`ifdef RESERVOIR_NL_EN
    if (sum > fx_one(FRAC_BITS)) sum = fx_one(FRAC_BITS);
    else if (sum < -fx_one(FRAC_BITS)) sum = -fx_one(FRAC_BITS);
`endif
    return sum[DATA_WIDTH-1:0];
  endfunction

  // Pure combinational node value.
  always_comb begin
    x_o = node_update(u_i, mask_bit_i, alpha_i, beta_i, d_i);
  end

endmodule

// File: rtl/dfr_reservoir_core.sv
// Delayed-feedback reservoir core. One accepted sample is expanded into
// VIRTUAL_NODES node values, each mixing the masked, alpha-scaled sample with
// beta times the same node's value from the previous frame (delay line).
// Build option: RESERVOIR_NL_EN (hard-tanh clamp inside reservoir_node_mac).
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// s_ready is high only in IDLE (and not during reset). On the output side,
// dout/m_idx/m_last hold steady while m_valid && !m_ready; a new node is
// produced only when the output register is empty or being consumed.
module dfr_reservoir_core
  import reservoir_pkg::*;
#(
  parameter int unsigned VIRTUAL_NODES = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FRAC_BITS     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [DATA_WIDTH-1:0]            alpha,
  input  logic [DATA_WIDTH-1:0]            beta,
  input  logic [VIRTUAL_NODES-1:0]         mask,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(VIRTUAL_NODES)-1:0] m_idx,
  output logic                             m_last
);

  localparam int unsigned IW = $clog2(VIRTUAL_NODES);
  localparam logic [IW-1:0] LAST_IDX = IW'(VIRTUAL_NODES - 1);

  state_e                  state_q, state_d;
  logic                    ready_q;
  logic [IW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   u_q, alpha_q, beta_q;
  logic [VIRTUAL_NODES-1:0] mask_q;
  logic [DATA_WIDTH-1:0]   d_q [VIRTUAL_NODES];
  logic                    m_valid_q, m_last_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic [IW-1:0]           m_idx_q;

  logic                    accept;
  logic                    step;
  logic                    step_last;
  logic [DATA_WIDTH-1:0]   x_node;

  assign accept    = s_valid && ready_q;
  assign step      = (state_q == RUN) && (!m_valid_q || m_ready);
  assign step_last = step && (cnt_q == LAST_IDX);

  assign s_ready = ready_q;
  assign m_valid = m_valid_q;
  assign dout    = dout_q;
  assign m_idx   = m_idx_q;
  assign m_last  = m_last_q;

  reservoir_node_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mac (
    .u_i       (u_q),
    .mask_bit_i(mask_q[cnt_q]),
    .alpha_i   (alpha_q),
    .beta_i    (beta_q),
    .d_i       (d_q[cnt_q]),
    .x_o       (x_node)
  );

  // FSM next state: accept a sample in IDLE, return after the last node.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (step_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and input-ready flag; ready is low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
    end
  end

  // Frame registers and node counter, loaded on accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      u_q     <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      u_q     <= din;
      alpha_q <= alpha;
      beta_q  <= beta;
      mask_q  <= mask;
      cnt_q   <= '0;
    end else if (step) begin
      cnt_q   <= step_last ? '0 : cnt_q + 1'b1;
    end
  end

  // Delay line: each node step overwrites that node's previous-frame value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(VIRTUAL_NODES); i++) d_q[i] <= '0;
    end else if (step) begin
      d_q[cnt_q] <= x_node;
    end
  end

  // Output register: load on a node step, otherwise drain on m_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid_q <= 1'b0;
      dout_q    <= '0;
      m_idx_q   <= '0;
      m_last_q  <= 1'b0;
    end else if (step) begin
      m_valid_q <= 1'b1;
      dout_q    <= x_node;
      m_idx_q   <= cnt_q;
      m_last_q  <= (cnt_q == LAST_IDX);
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dfr_reservoir_core.sv
// Directed bench for dfr_reservoir_core with VIRTUAL_NODES=4, 32-bit Q16.16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dfr_reservoir_core;

  localparam int VN = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] alpha = '0;
  logic [DW-1:0] beta = '0;
  logic [VN-1:0] mask = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] dout;
  logic [1:0]    m_idx;
  logic          m_last;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_d [VN];
  logic [1:0]    got_i [VN];
  logic          got_l [VN];
  logic          got_r [VN];
  logic          got_ok;

  dfr_reservoir_core #(
    .VIRTUAL_NODES(VN),
    .DATA_WIDTH   (DW),
    .FRAC_BITS    (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .din    (din),
    .alpha  (alpha),
    .beta   (beta),
    .mask   (mask),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .dout   (dout),
    .m_idx  (m_idx),
    .m_last (m_last)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [DW-1:0] u, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [VN-1:0] m);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: s_ready=%b expected 1 within 50 cycles", s_ready);
    end
    din = u; alpha = a; beta = b; mask = m; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    din = 32'hDEAD_BEEF; alpha = 32'h7FFF_FFFF; beta = 32'h7FFF_FFFF; mask = '0;
  endtask

  // Records VN consecutive transferred nodes (m_ready held high by caller).
  task automatic collect_frame();
    int k, n;
    k = 0; n = 0;
    got_ok = 1'b1;
    while (k < VN) begin
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        got_d[k] = dout; got_i[k] = m_idx; got_l[k] = m_last; got_r[k] = s_ready;
        k++;
      end
      if (k < VN) begin
        @(negedge clk);
        n++;
        if (n > 40) begin
          got_ok = 1'b0;
          break;
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || dout !== '0 || s_ready !== 1'b0 || m_idx !== 2'd0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: m_valid=%b dout=%h s_ready=%b m_idx=%0d m_last=%b expected 0 0 0 0 0",
               m_valid, dout, s_ready, m_idx, m_last);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: s_ready=%b expected 1", s_ready);
    end
  endtask

  task automatic test_mask();
    logic [DW-1:0] exp_d [VN];
    exp_d[0] = 32'h0000_8000; exp_d[1] = 32'hFFFF_8000;
    exp_d[2] = 32'h0000_8000; exp_d[3] = 32'hFFFF_8000;
    send_sample(32'h8000, 32'h10000, 32'h0, 4'b0101);
    collect_frame();
    checks++;
    if (!got_ok) begin
      errors++;
      $display("FAIL mask_timeout: collected fewer than %0d nodes", VN);
    end
    for (int i = 0; i < VN; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_i[i] !== 2'(i) || got_l[i] !== (i == VN - 1)) begin
        errors++;
        $display("FAIL mask_node%0d: dout=%h idx=%0d last=%b expected %h %0d %b",
                 i, got_d[i], got_i[i], got_l[i], exp_d[i], i, (i == VN - 1));
      end
    end
    checks++;
    if (got_r[0] !== 1'b0 || got_r[2] !== 1'b0) begin
      errors++;
      $display("FAIL mask_ready_run: s_ready node0=%b node2=%b expected 0 0", got_r[0], got_r[2]);
    end
    checks++;
    if (got_r[3] !== 1'b1) begin
      errors++;
      $display("FAIL mask_ready_back: s_ready with last node=%b expected 1", got_r[3]);
    end
  endtask

  task automatic test_feedback();
    logic [DW-1:0] exp_f [2];
    exp_f[0] = 32'h8000; exp_f[1] = 32'hC000;
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      send_sample(32'h10000, 32'h8000, 32'h8000, 4'b1111);
      collect_frame();
      for (int i = 0; i < VN; i++) begin
        checks++;
        if (!got_ok || got_d[i] !== exp_f[f]) begin
          errors++;
          $display("FAIL feedback_f%0d_node%0d: dout=%h ok=%b expected %h", f, i, got_d[i], got_ok, exp_f[f]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [DW-1:0] exp_c [3];
`ifdef RESERVOIR_NL_EN
    exp_c[0] = 32'h10000; exp_c[1] = 32'h10000; exp_c[2] = 32'h10000;
`else
    exp_c[0] = 32'h10000; exp_c[1] = 32'h20000; exp_c[2] = 32'h30000;
`endif
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      send_sample(32'h10000, 32'h10000, 32'h10000, 4'b1111);
      collect_frame();
      for (int i = 0; i < VN; i++) begin
        checks++;
        if (!got_ok || got_d[i] !== exp_c[f]) begin
          errors++;
          $display("FAIL clamp_f%0d_node%0d: dout=%h ok=%b expected %h", f, i, got_d[i], got_ok, exp_c[f]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    apply_reset();
    // mask 0010: node1 = +1.0, others = -1.0
    send_sample(32'h10000, 32'h10000, 32'h0, 4'b0010);
    n = 0;
    while (!(m_valid === 1'b1 && m_idx === 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_valid === 1'b1 && m_idx === 2'd1 && dout === 32'h10000)) begin
      errors++;
      $display("FAIL bp_reach_idx1: m_valid=%b m_idx=%0d dout=%h expected 1 1 00010000", m_valid, m_idx, dout);
    end
    m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_idx !== 2'd1 || dout !== 32'h10000 || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_c%0d: m_valid=%b m_idx=%0d dout=%h s_ready=%b expected 1 1 00010000 0",
                 c, m_valid, m_idx, dout, s_ready);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_idx !== 2'd2 || dout !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL bp_idx2: m_valid=%b m_idx=%0d dout=%h expected 1 2 ffff0000", m_valid, m_idx, dout);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_idx !== 2'd3 || m_last !== 1'b1 || dout !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL bp_idx3: m_valid=%b m_idx=%0d m_last=%b dout=%h expected 1 3 1 ffff0000",
               m_valid, m_idx, m_last, dout);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_midframe_reset();
    int n;
    apply_reset();
    send_sample(32'h10000, 32'h8000, 32'h8000, 4'b1111);
    collect_frame();
    checks++;
    if (!got_ok || got_d[0] !== 32'h8000) begin
      errors++;
      $display("FAIL mfr_prime: dout=%h ok=%b expected 00008000", got_d[0], got_ok);
    end
    send_sample(32'h10000, 32'h8000, 32'h8000, 4'b1111);
    n = 0;
    while (!(m_valid === 1'b1 && m_idx === 2'd1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(m_valid === 1'b1 && m_idx === 2'd1 && dout === 32'hC000)) begin
      errors++;
      $display("FAIL mfr_idx1: m_valid=%b m_idx=%0d dout=%h expected 1 1 0000c000", m_valid, m_idx, dout);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || dout !== '0 || m_idx !== 2'd0 || m_last !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL mfr_outputs: m_valid=%b dout=%h m_idx=%0d m_last=%b s_ready=%b expected 0 0 0 0 0",
               m_valid, dout, m_idx, m_last, s_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    send_sample(32'h10000, 32'h8000, 32'h8000, 4'b1111);
    collect_frame();
    for (int i = 0; i < VN; i++) begin
      checks++;
      if (!got_ok || got_d[i] !== 32'h8000) begin
        errors++;
        $display("FAIL mfr_after_node%0d: dout=%h ok=%b expected 00008000", i, got_d[i], got_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_feedback();
    test_clamp();
    test_backpressure();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
